accel_sequencer: RTL and testbench
==================================

Name: accel_sequencer

Overview:
Micro-sequencer directly upstream of the accelerator ALU/register-file stage. It holds a small program of 8-bit ALU instructions loaded by the host, then steps through them on a start command. For each instruction it drives the ALU opcode and operand selects, captures the ALU result and issues a one-cycle write-back to the destination register. The host therefore runs multi-step ALU sequences without issuing a bus write per operation.

Parameters:
DEPTH, 8, program memory entries; power of two, 2..16
ADDR_W, $clog2(DEPTH), program counter / program address width

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
prog_we  in  1  program memory write strobe
prog_addr  in  ADDR_W  program memory write address
prog_data  in  8  instruction: [1:0] op, [3:2] sel_a, [5:4] sel_b, [7:6] dest
prog_len  in  ADDR_W+1  instruction count, sampled on start
start  in  1  run request, level-sampled each cycle
busy  out  1  high from the cycle after an accepted start through the last WB
done  out  1  one-cycle pulse at completion
pc  out  ADDR_W  index of the current instruction
alu_op  out  4  to ALU opcode: {2'b00, op}
alu_sel_a  out  2  to ALU operand-A select
alu_sel_b  out  2  to ALU operand-B select
alu_result  in  8  from ALU output (combinational)
wb_en  out  1  register-file write enable, one cycle per instruction
wb_dest  out  2  write-back register index: 0=A, 1=B, 2=C, 3=D
wb_data  out  8  write-back value

Behaviour:
- Reset (asynchronous, active-low) clears all outputs and internal state to 0, forces IDLE and clears the program memory to 8'h00. Reset mid-run aborts immediately and issues no further wb_en.
- All outputs are registered.
- States: IDLE, FETCH, EXEC, WB, DONE.
- IDLE:
  - prog_we writes prog_data into mem[prog_addr].
  - start with prog_len != 0: latch min(prog_len, DEPTH) as len, set pc=0, go to FETCH.
  - start with prog_len == 0: go to DONE.
- FETCH: ir <= mem[pc]; go to EXEC.
- EXEC: alu_op, alu_sel_a and alu_sel_b are driven from ir and stay stable until the next FETCH. Go to WB.
- WB: wb_en=1, wb_dest=ir[7:6], wb_data=alu_result sampled at the end of EXEC.
  - If pc == len-1, go to DONE.
  - Otherwise pc <= pc+1 and go to FETCH.
- DONE: done=1 for one cycle; go to IDLE.
- Latency: start sampled at edge 0 gives WB of instruction k during cycle 3k+3 and done during cycle 3N+1 (N = len). For len=0, done is in cycle 1.
- busy is high in FETCH, EXEC and WB, low in IDLE and DONE.
- Hazards: a write-back completes before the next EXEC, so chained dependencies read updated values. No stall logic.
- While not in IDLE, prog_we and start are ignored. Memory is unchanged and the run is unaffected.
- Op values 2 and 3 are passed through unchanged; their result is defined by the ALU.
- prog_len > DEPTH is clamped to DEPTH.

Optional Feature:
ACCEL_SEQ_LOOP_EN
- When defined, adds inputs loop (1 bit, sampled with start) and stop (1 bit).
  - If loop was set at start, WB of the last instruction goes to FETCH with pc=0 instead of DONE.
  - A stop pulse anywhere is latched. At the next WB of the last instruction the sequencer goes to DONE.
  - The stop latch clears in IDLE.
- When undefined, these ports do not exist and every run is single-pass.

Test Plan:
- Bench models registers A=5, B=3 and an add/sub ALU. Load mem[0]=8'hD0, prog_len=1, start: wb_en in cycle 3 with wb_dest=3, wb_data=8; done in cycle 4; busy high in cycles 1–3.
- Load mem[0]=8'hD0, mem[1]=8'h8D (C = D - A), prog_len=2: first WB D=8 in cycle 3; second WB in cycle 6 with wb_dest=2, wb_data=3; done in cycle 7; alu_op=1 during the second EXEC.
- prog_len=0: done in cycle 1; busy and wb_en never assert.
- During a 2-instruction run, pulse start and write prog_we to addr 0 with 8'hFF: no restart; a rerun still produces the same results, proving memory is unchanged.
- Assert rst_n=0 during EXEC: all outputs 0 without waiting for a clock edge; no wb_en; state IDLE after release; mem reads 8'h00 on a rerun (wb_data=10, i.e. A+A).
- With ACCEL_SEQ_LOOP_EN, loop=1, len=1, D0 program: wb_en every 3 cycles. Pulse stop: exactly one further WB, then done.

Source files
------------

// File: rtl/accel_sequencer.sv
// rtl/accel_sequencer.sv - micro-sequencer stepping a host-loaded ALU program
//
// Purpose:
//   Holds DEPTH 8-bit ALU instructions written by the host. On start it runs
//   the first min(prog_len, DEPTH) instructions. Each one passes through
//   FETCH, EXEC and WB, then the run ends in DONE. In FETCH the instruction
//   is read from memory. In EXEC its opcode and operand selects are driven to
//   the ALU. In WB the captured ALU result is written back as a one-cycle
//   wb_en pulse.
//   Instruction format: [1:0] op, [3:2] sel_a, [5:4] sel_b, [7:6] dest.
//
// Optional feature (macro ACCEL_SEQ_LOOP_EN):
//   Adds the loop and stop inputs. If loop was set at start, the program
//   restarts from pc=0 after its last write-back. A latched stop pulse makes
//   the next last-instruction write-back finish the run instead.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   prog_we/addr/data  program memory write port (honoured only in IDLE)
//   prog_len       instruction count, sampled with start
//   start          run request, level-sampled in IDLE
//   loop, stop     (ACCEL_SEQ_LOOP_EN only) repeat mode / stop request
//   busy           high in FETCH, EXEC and WB
//   done           one-cycle completion pulse
//   pc             index of the current instruction
//   alu_op, alu_sel_a, alu_sel_b   ALU controls, stable from EXEC to next FETCH
//   alu_result     combinational ALU output
//   wb_en, wb_dest, wb_data        register-file write-back

module accel_sequencer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [7:0]        prog_data,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              start,
`ifdef ACCEL_SEQ_LOOP_EN
  input  logic              loop,
  input  logic              stop,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        alu_op,
  output logic [1:0]        alu_sel_a,
  output logic [1:0]        alu_sel_b,
  input  logic [7:0]        alu_result,
  output logic              wb_en,
  output logic [1:0]        wb_dest,
  output logic [7:0]        wb_data
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wb_en_q, wb_en_d;
  logic [7:0]        wb_data_q, wb_data_d;
  logic [7:0]        mem_q [DEPTH];

  logic              mem_we;
  logic              last;
  logic              rerun;
  logic [ADDR_W:0]   len_m1;

`ifdef ACCEL_SEQ_LOOP_EN
  logic loop_q, loop_d;
  logic stop_q, stop_d;
  // A stop seen in the deciding WB cycle itself also ends the run.
  assign rerun = loop_q & ~(stop_q | stop);
`else
  assign rerun = 1'b0;
`endif

  // len is at least 1 whenever it is used, so len-1 fits in the pc width.
  assign len_m1 = len_q - (ADDR_W+1)'(1);
  assign last   = (pc_q == len_m1[ADDR_W-1:0]);
  assign mem_we = (state_q == S_IDLE) && prog_we;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wb_en_d   = 1'b0;
    wb_data_d = wb_data_q;
`ifdef ACCEL_SEQ_LOOP_EN
    loop_d    = loop_q;
    stop_d    = stop_q | stop;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef ACCEL_SEQ_LOOP_EN
        stop_d = 1'b0;
`endif
        if (start) begin
          if (prog_len != '0) begin
            len_d   = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
            pc_d    = '0;
            busy_d  = 1'b1;
            state_d = S_FETCH;
`ifdef ACCEL_SEQ_LOOP_EN
            loop_d  = loop;
`endif
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_FETCH: begin
        ir_d    = mem_q[pc_q];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // The ALU result is captured here so the WB cycle presents a value
        // that does not depend on the ALU inputs changing afterwards.
        wb_en_d   = 1'b1;
        wb_data_d = alu_result;
        state_d   = S_WB;
      end
      S_WB: begin
        if (!last) begin
          pc_d    = pc_q + PC_ONE;
          state_d = S_FETCH;
        end else if (rerun) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      pc_q      <= '0;
      ir_q      <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_data_q <= 8'h00;
`ifdef ACCEL_SEQ_LOOP_EN
      loop_q    <= 1'b0;
      stop_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wb_en_q   <= wb_en_d;
      wb_data_q <= wb_data_d;
`ifdef ACCEL_SEQ_LOOP_EN
      loop_q    <= loop_d;
      stop_q    <= stop_d;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (mem_we) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  // The ALU controls and write-back index come straight from the
  // instruction register. They change only when FETCH loads ir and are
  // therefore stable from EXEC until the next FETCH.
  assign alu_op    = {2'b00, ir_q[1:0]};
  assign alu_sel_a = ir_q[3:2];
  assign alu_sel_b = ir_q[5:4];
  assign wb_dest   = ir_q[7:6];

  assign busy      = busy_q;
  assign done      = done_q;
  assign pc        = pc_q;
  assign wb_en     = wb_en_q;
  assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_accel_sequencer.sv
// tb/tb_accel_sequencer.sv - scoreboard bench for accel_sequencer

module tb_accel_sequencer;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [7:0]    prog_data = 8'h00;
  logic [AW:0]   prog_len = '0;
  logic          start = 1'b0;
`ifdef ACCEL_SEQ_LOOP_EN
  logic          loop = 1'b0;
  logic          stop = 1'b0;
`endif
  logic          busy, done, wb_en;
  logic [AW-1:0] pc;
  logic [3:0]    alu_op;
  logic [1:0]    alu_sel_a, alu_sel_b, wb_dest;
  logic [7:0]    alu_result, wb_data;

  always #5 clk = ~clk;

  accel_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_len(prog_len), .start(start),
`ifdef ACCEL_SEQ_LOOP_EN
    .loop(loop), .stop(stop),
`endif
    .busy(busy), .done(done), .pc(pc), .alu_op(alu_op),
    .alu_sel_a(alu_sel_a), .alu_sel_b(alu_sel_b), .alu_result(alu_result),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data)
  );

  typedef struct {
    bit         is_wb;
    int         edge_i;
    logic [1:0] dest;
    logic [7:0] data;
    int         pc_i;
    int         op;
    int         sa;
    int         sb;
  } ev_t;

  ev_t        expq[$];
  int         compared = 0;
  int         mismatched = 0;
  int         edge_cnt = 0;
  int         busy_lo = 0;
  int         busy_hi = -1;
  logic [7:0] env_r[4];
  logic [7:0] init_r[4];
  logic       reg_init = 1'b0;
  logic [7:0] mm[DEPTH];
  logic [7:0] mr[4];

  // Environment ALU: 0 add, 1 sub, 2 and, 3 xor.
  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a ^ b;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result = alu_f(alu_op, env_r[alu_sel_a], env_r[alu_sel_b]);

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Environment register file A..D, written by the DUT write-back port.
  always @(posedge clk) begin
    if (reg_init) begin
      for (int i = 0; i < 4; i++) env_r[i] <= init_r[i];
    end else if (wb_en) begin
      env_r[wb_dest] <= wb_data;
    end
  end

  task automatic chk(input string name, input int act, input int exp_v);
    compared++;
    if (act != exp_v) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Monitor: compares busy every cycle and pops one expected event for each
  // wb_en or done pulse.
  always @(negedge clk) begin
    int  last;
    ev_t e;
    if (rst_n) begin
      last = edge_cnt - 1;
      chk("busy", int'(busy), int'(last >= busy_lo && last <= busy_hi));
      if (wb_en || done) begin
        if (expq.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_event: got wb_en=%0d done=%0d expected none (t=%0t)", wb_en, done, $time);
        end else begin
          e = expq.pop_front();
          chk("wb_en", int'(wb_en), int'(e.is_wb));
          chk("done", int'(done), int'(!e.is_wb));
          chk("event_cycle", last, e.edge_i);
          if (e.is_wb && wb_en) begin
            chk("wb_dest", int'(wb_dest), int'(e.dest));
            chk("wb_data", int'(wb_data), int'(e.data));
            chk("pc", int'(pc), e.pc_i);
            chk("alu_op", int'(alu_op), e.op);
            chk("alu_sel_a", int'(alu_sel_a), e.sa);
            chk("alu_sel_b", int'(alu_sel_b), e.sb);
          end
        end
      end
    end
  end

  task automatic init_regs(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    @(negedge clk);
    init_r[0] = a; init_r[1] = b; init_r[2] = c; init_r[3] = d;
    mr[0] = a; mr[1] = b; mr[2] = c; mr[3] = d;
    reg_init = 1'b1;
    @(negedge clk);
    reg_init = 1'b0;
  endtask

  task automatic load(input int addr, input logic [7:0] data);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = addr[AW-1:0];
    prog_data = data;
    mm[addr]  = data;
    @(negedge clk);
    prog_we   = 1'b0;
  endtask

  // Issues start and pushes the whole expected response. With iters > 1 the
  // program is expected to repeat that many times (loop mode).
  task automatic run(input int len, input int iters, output int s);
    int   n, t, d, sa, sb, op;
    ev_t  e;
    logic [7:0] ins, r;
    s = edge_cnt;
    n = (len > DEPTH) ? DEPTH : len;
    t = 0;
    start    = 1'b1;
    prog_len = len[AW:0];
`ifdef ACCEL_SEQ_LOOP_EN
    loop     = (iters > 1);
`endif
    if (n > 0) begin
      for (int it = 0; it < iters; it++) begin
        for (int k = 0; k < n; k++) begin
          ins = mm[k];
          op = int'(ins[1:0]); sa = int'(ins[3:2]); sb = int'(ins[5:4]); d = int'(ins[7:6]);
          r = alu_f(4'(op), mr[sa], mr[sb]);
          e.is_wb = 1'b1; e.edge_i = s + 3*t + 2; e.dest = 2'(d); e.data = r;
          e.pc_i = k; e.op = op; e.sa = sa; e.sb = sb;
          expq.push_back(e);
          mr[d] = r;
          t++;
        end
      end
    end
    e.is_wb = 1'b0; e.edge_i = s + 3*t; e.dest = 2'd0; e.data = 8'h00;
    e.pc_i = 0; e.op = 0; e.sa = 0; e.sb = 0;
    expq.push_back(e);
    busy_lo = s;
    busy_hi = s + 3*t - 1;
    @(negedge clk);
    start = 1'b0;
`ifdef ACCEL_SEQ_LOOP_EN
    loop  = 1'b0;
`endif
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && expq.size() != 0; i++) @(negedge clk);
    if (expq.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL timeout: got %0d pending events expected 0", expq.size());
      expq.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_wb_en"}, int'(wb_en), 0);
    chk({tag, "_pc"}, int'(pc), 0);
    chk({tag, "_alu_op"}, int'(alu_op), 0);
    chk({tag, "_sel_a"}, int'(alu_sel_a), 0);
    chk({tag, "_sel_b"}, int'(alu_sel_b), 0);
    chk({tag, "_wb_dest"}, int'(wb_dest), 0);
    chk({tag, "_wb_data"}, int'(wb_data), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int s;
    for (int i = 0; i < DEPTH; i++) mm[i] = 8'h00;
    #1;
    check_zero_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single instruction: D = A + B.
    init_regs(8'd5, 8'd3, 8'd0, 8'd0);
    load(0, 8'hD0);
    run(1, 1, s);
    wait_idle();

    // Two chained instructions: D = A + B, then C = D - A.
    init_regs(8'd5, 8'd3, 8'd0, 8'd0);
    load(1, 8'h8D);
    run(2, 1, s);
    wait_idle();

    // Empty program completes immediately.
    run(0, 1, s);
    wait_idle();

    // start and prog_we during a run are ignored.
    init_regs(8'd5, 8'd3, 8'd0, 8'd0);
    run(2, 1, s);
    @(negedge clk);
    start = 1'b1; prog_we = 1'b1; prog_addr = '0; prog_data = 8'hFF; prog_len = 4'd1;
    @(negedge clk);
    start = 1'b0; prog_we = 1'b0;
    wait_idle();
    init_regs(8'd5, 8'd3, 8'd0, 8'd0);
    run(2, 1, s);
    wait_idle();

    // Asynchronous reset during EXEC of the first instruction.
    init_regs(8'd5, 8'd3, 8'd0, 8'd0);
    run(2, 1, s);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_zero_outputs("midrun_reset");
    expq.delete();
    busy_hi = -1;
    for (int i = 0; i < DEPTH; i++) mm[i] = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    init_regs(8'd5, 8'd3, 8'd0, 8'd0);
    run(1, 1, s);
    wait_idle();

`ifdef ACCEL_SEQ_LOOP_EN
    // Loop mode: four passes of a one-instruction program, stopped in pass 4.
    init_regs(8'd5, 8'd3, 8'd0, 8'd0);
    load(0, 8'hD0);
    run(1, 4, s);
    for (int i = 0; i < 100 && (edge_cnt - 1) < s + 9; i++) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_idle();
`endif

    // Randomized programs, lengths including 0 and values above DEPTH.
    for (int it = 0; it < 24; it++) begin
      init_regs(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      for (int a = 0; a < DEPTH; a++) load(a, 8'($urandom));
      run(int'($urandom_range(0, 15)), 1, s);
      wait_idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
